// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions for the EX-stage multiply/divide unit:
// opcode/shamt encodings, FSM states and the internal operation kind.
package legv8_pkg;

    localparam logic [10:0] OP_MUL   = 11'h4D8;
    localparam logic [10:0] OP_UMULH = 11'h4DE;
    localparam logic [10:0] OP_DIV   = 11'h4D6;

    localparam logic [5:0] SH_SDIV = 6'h02;
    localparam logic [5:0] SH_UDIV = 6'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } muldiv_state_t;

    typedef enum logic [1:0] {
        K_MUL,
        K_UMULH,
        K_SDIV,
        K_UDIV
    } muldiv_kind_t;

    function automatic logic is_div(input muldiv_kind_t kind);
        return (kind == K_SDIV) || (kind == K_UDIV);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Radix-2 iterative MUL/UMULH/SDIV/UDIV unit for the EX stage.
// One shared 2*XLEN accumulator serves as product register or remainder:quotient pair.
module ex_muldiv
    import legv8_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [10:0]     alu_ctrl_data,
    input  logic [5:0]      shamt,
    input  logic [XLEN-1:0] read1,
    input  logic [XLEN-1:0] read2,
    input  logic [4:0]      write_reg,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      Write_reg
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t     state;
    muldiv_kind_t      kind;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand_b;
    logic              negate;
    logic              div_zero;
    logic [4:0]        rd_pending;

    // Start decode
    logic         start_valid;
    muldiv_kind_t start_kind;

    always_comb begin
        start_valid = 1'b0;
        start_kind  = K_MUL;
        unique case (alu_ctrl_data)
            OP_MUL: begin
                start_valid = 1'b1;
                start_kind  = K_MUL;
            end
            OP_UMULH: begin
                start_valid = 1'b1;
                start_kind  = K_UMULH;
            end
            OP_DIV: begin
                if (shamt == SH_SDIV) begin
                    start_valid = 1'b1;
                    start_kind  = K_SDIV;
                end else if (shamt == SH_UDIV) begin
                    start_valid = 1'b1;
                    start_kind  = K_UDIV;
                end
            end
            default: ;
        endcase
    end

    // SDIV works on magnitudes; |MIN| is 2^(XLEN-1) as an unsigned value, which is exact.
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            start_div;
    logic            start_neg;

    always_comb begin
        start_div = is_div(start_kind);
        mag1      = read1;
        mag2      = read2;
        start_neg = 1'b0;
        if (start_kind == K_SDIV) begin
            if (read1[XLEN-1]) mag1 = -read1;
            if (read2[XLEN-1]) mag2 = -read2;
            start_neg = read1[XLEN-1] ^ read2[XLEN-1];
        end
    end

    // Multiply step: conditional add into the upper half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_b} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
    end

    // Restoring divide step: shift left, trial-subtract, keep on no borrow.
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        rem_shift = acc[2*XLEN-1:XLEN-1];
        diff      = rem_shift - {1'b0, operand_b};
        if (diff[XLEN])
            div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    logic [XLEN-1:0] fix_value;

    always_comb begin
        unique case (kind)
            K_MUL:   fix_value = acc[XLEN-1:0];
            K_UMULH: fix_value = acc[2*XLEN-1:XLEN];
            default: begin
                if (div_zero)    fix_value = '0;
                else if (negate) fix_value = -acc[XLEN-1:0];
                else             fix_value = acc[XLEN-1:0];
            end
        endcase
    end

    assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            kind       <= K_MUL;
            count      <= '0;
            acc        <= '0;
            operand_b  <= '0;
            negate     <= 1'b0;
            div_zero   <= 1'b0;
            rd_pending <= '0;
            done       <= 1'b0;
            result     <= '0;
            Write_reg  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start && start_valid) begin
                            kind       <= start_kind;
                            rd_pending <= write_reg;
                            count      <= CW'(XLEN - 1);
                            acc        <= {{XLEN{1'b0}}, start_div ? mag1 : read2};
                            operand_b  <= start_div ? mag2 : read1;
                            negate     <= start_neg;
                            div_zero   <= start_div && (read2 == '0);
                            if (!start_div)
                                state <= S_MUL;
                            else if (read2 == '0)
                                state <= S_FIX;
                            else
                                state <= S_DIV;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_MUL: begin
                        acc <= mul_next;
                        if (count == '0) state <= S_FIX;
                        else             count <= count - 1'b1;
                    end
                    S_DIV: begin
                        acc <= div_next;
                        if (count == '0) state <= S_FIX;
                        else             count <= count - 1'b1;
                    end
                    S_FIX: begin
                        result    <= fix_value;
                        Write_reg <= rd_pending;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
